// File: rtl/syscall_console_unit.sv
// syscall_console_unit: writeback-stage syscall service engine.
// Services print_char (11), print_string (4), print_hex (34), exit (10) and
// exit2 (17). Output bytes go through a small FIFO to a valid/ready console sink.
// Optional feature macro SYSCALL_STATS_EN adds cycle/call counters and an
// exit report; without it the counters, their ports and the report are absent.
// Console handshake: a byte moves on a rising edge where tx_valid && tx_ready;
// tx_valid stays high and tx_data stays stable until that happens.
// print_hex assumes XLEN >= 32 and prints the low 32 bits of a0.
module syscall_console_unit #(
   parameter int XLEN      = 32,
   parameter int FIFO_LOG2 = 3,
   parameter int MAX_STR   = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            syscall_w,
   input  logic [XLEN-1:0] v0,
   input  logic [XLEN-1:0] a0,
   output logic            busy,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic [7:0]      mem_rdata,
   input  logic            mem_ack,
   output logic            tx_valid,
   output logic [7:0]      tx_data,
   input  logic            tx_ready,
   output logic            halt,
   output logic [XLEN-1:0] exit_code,
   output logic            err_pulse
`ifdef SYSCALL_STATS_EN
   ,
   output logic [63:0]     cycle_cnt,
   output logic [31:0]     call_cnt
`endif
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int LEN_W = $clog2(MAX_STR + 1);

   localparam logic [XLEN-1:0] SC_PRINT_CHAR = XLEN'(11);
   localparam logic [XLEN-1:0] SC_PRINT_STR  = XLEN'(4);
   localparam logic [XLEN-1:0] SC_PRINT_HEX  = XLEN'(34);
   localparam logic [XLEN-1:0] SC_EXIT       = XLEN'(10);
   localparam logic [XLEN-1:0] SC_EXIT2      = XLEN'(17);

   localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
   localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2 + 1)'(1);
   localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0]     LEN_LAST = LEN_W'(MAX_STR - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PUSH, S_STR_REQ, S_HEX, S_DRAIN, S_HALT
   } state_t;

   state_t state, state_nxt;

   // FIFO storage and occupancy
   logic [7:0]           fifo_mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FIFO_LOG2:0]   count;
   logic                 full, empty, do_pop;

   // Service datapath registers
   logic [LEN_W-1:0] len;
   logic [31:0]      hex_word;
   logic [2:0]       nib_cnt;
   logic [7:0]       pend_byte;
   logic             pend_str;

   // Control strobes from the next-state logic
   logic       push_req, err_nxt, accept;
   logic [7:0] push_byte;
   logic       ld_str, str_adv, ld_hex, hex_adv, ld_exit, ld_pend, pend_str_nxt;
   logic [7:0] pend_src;
   logic [3:0] nib;
   logic [7:0] hex_char;

   // full is taken from the registered count, so a same-cycle pop never frees a slot
   assign full     = count[FIFO_LOG2];
   assign empty    = (count == '0);
   assign do_pop   = !empty && tx_ready;
   assign tx_valid = !empty;
   assign tx_data  = fifo_mem[rd_ptr];
   assign busy     = (state != S_IDLE);
   assign halt     = (state == S_HALT);
   assign mem_req  = (state == S_STR_REQ);

   assign nib      = hex_word[31:28];
   assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_nxt    = state;
      push_req     = 1'b0;
      push_byte    = 8'h00;
      err_nxt      = 1'b0;
      accept       = 1'b0;
      ld_str       = 1'b0;
      str_adv      = 1'b0;
      ld_hex       = 1'b0;
      hex_adv      = 1'b0;
      ld_exit      = 1'b0;
      ld_pend      = 1'b0;
      pend_src     = 8'h00;
      pend_str_nxt = 1'b0;
      // a syscall arriving while a service is running is dropped and flagged
      if (syscall_w && (state != S_IDLE)) err_nxt = 1'b1;
      case (state)
         S_IDLE: begin
            if (syscall_w) begin
               if (v0 == SC_PRINT_CHAR) begin
                  accept = 1'b1;
                  if (!full) begin
                     push_req  = 1'b1;
                     push_byte = a0[7:0];
                  end else begin
                     ld_pend   = 1'b1;
                     pend_src  = a0[7:0];
                     state_nxt = S_PUSH;
                  end
               end else if (v0 == SC_PRINT_STR) begin
                  accept    = 1'b1;
                  ld_str    = 1'b1;
                  state_nxt = S_STR_REQ;
               end else if (v0 == SC_PRINT_HEX) begin
                  accept    = 1'b1;
                  ld_hex    = 1'b1;
                  state_nxt = S_HEX;
               end else if ((v0 == SC_EXIT) || (v0 == SC_EXIT2)) begin
                  accept    = 1'b1;
                  ld_exit   = 1'b1;
                  state_nxt = S_DRAIN;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_PUSH: begin
            if (!full) begin
               push_req  = 1'b1;
               push_byte = pend_byte;
               if (pend_str) begin
                  str_adv = 1'b1;
                  if (len == LEN_LAST) begin
                     err_nxt   = 1'b1;
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt = S_STR_REQ;
                  end
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_STR_REQ: begin
            if (mem_ack) begin
               if (mem_rdata == 8'h00) begin
                  state_nxt = S_IDLE;
               end else if (!full) begin
                  push_req  = 1'b1;
                  push_byte = mem_rdata;
                  str_adv   = 1'b1;
                  if (len == LEN_LAST) begin
                     err_nxt   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end else begin
                  ld_pend      = 1'b1;
                  pend_src     = mem_rdata;
                  pend_str_nxt = 1'b1;
                  state_nxt    = S_PUSH;
               end
            end
         end
         S_HEX: begin
            if (!full) begin
               push_req  = 1'b1;
               push_byte = hex_char;
               hex_adv   = 1'b1;
               if (nib_cnt == 3'd7) state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (empty) state_nxt = S_HALT;
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Console FIFO: push only when not full, pop on the tx handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= 8'h00;
      end else begin
         if (push_req) begin
            fifo_mem[wr_ptr] <= push_byte;
            wr_ptr           <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (push_req && !do_pop)      count <= count + CNT_ONE;
         else if (!push_req && do_pop) count <= count - CNT_ONE;
      end
   end

   // Service datapath: string cursor, hex shifter, pending byte, exit code, error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         len       <= '0;
         hex_word  <= '0;
         nib_cnt   <= '0;
         pend_byte <= 8'h00;
         pend_str  <= 1'b0;
         exit_code <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= err_nxt;
         if (ld_str) begin
            mem_addr <= a0;
            len      <= '0;
         end else if (str_adv) begin
            mem_addr <= mem_addr + XLEN'(1);
            len      <= len + LEN_ONE;
         end
         if (ld_hex) begin
            hex_word <= a0[31:0];
            nib_cnt  <= 3'd0;
         end else if (hex_adv) begin
            hex_word <= {hex_word[27:0], 4'h0};
            nib_cnt  <= nib_cnt + 3'd1;
         end
         if (ld_pend) begin
            pend_byte <= pend_src;
            pend_str  <= pend_str_nxt;
         end
         if (ld_exit) exit_code <= (v0 == SC_EXIT2) ? a0 : '0;
      end
   end

`ifdef SYSCALL_STATS_EN
   // Run statistics: cycles since reset (frozen once halted) and accepted calls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= 64'd0;
         call_cnt  <= 32'd0;
      end else begin
         if (state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
         if (accept)          call_cnt  <= call_cnt + 32'd1;
      end
   end

   // Exit report printed once, on the transition into HALT
   always_ff @(posedge clk) begin
      if (rst_n && (state != S_HALT) && (state_nxt == S_HALT))
         $display("syscall_console_unit halt: cycles=%0d calls=%0d exit_code=%0d",
                  cycle_cnt, call_cnt, exit_code);
   end
`endif

endmodule

// File: tb/tb_syscall_console_unit.sv
// Bench for syscall_console_unit (default build, SYSCALL_STATS_EN undefined).
// Expected console bytes come from a behavioural model of each service
// (string text from the memory array, hex text from $sformatf) and are
// queued in exp_q; a tx monitor pops and compares every accepted byte.
module tb_syscall_console_unit;

   localparam int XLEN       = 32;
   localparam int FIFO_LOG2  = 3;
   localparam int TB_MAX_STR = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        syscall_w = 1'b0;
   logic [31:0] v0 = '0;
   logic [31:0] a0 = '0;
   logic        busy, mem_req, mem_ack, tx_valid, tx_ready, halt, err_pulse;
   logic [31:0] mem_addr, exit_code;
   logic [7:0]  mem_rdata, tx_data;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
   int ack_delay = -1;   // <0: random 0..3 cycles
   logic [7:0]  exp_q[$];
   logic [31:0] rd_addr_q[$];
   logic [7:0]  mem_model [0:1023];
   logic [7:0]  exp_b;

   syscall_console_unit #(.XLEN(XLEN), .FIFO_LOG2(FIFO_LOG2), .MAX_STR(TB_MAX_STR)) dut (
      .clk(clk), .rst_n(rst_n), .syscall_w(syscall_w), .v0(v0), .a0(a0),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .halt(halt), .exit_code(exit_code), .err_pulse(err_pulse)
   );

   // clock
   always #5 clk = ~clk;

   // sink ready driver
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // memory responder: one ack per request after a delay, dropped if the request vanishes
   initial begin
      logic [31:0] ra;
      int d;
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (mem_req === 1'b1) begin
            d  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            ra = mem_addr;
            for (int i = 0; i < d; i++) begin @(posedge clk); #1; end
            if (mem_req === 1'b1 && rst_n) begin
               mem_rdata = mem_model[ra[9:0]];
               mem_ack   = 1'b1;
               rd_addr_q.push_back(ra);
            end
         end
      end
   end

   // scoreboard: every accepted tx byte against the expected queue; count error pulses
   always @(negedge clk) begin
      if (rst_n && tx_valid === 1'b1 && tx_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %02h, required no byte", tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
               errors++;
               $display("FAIL tx_data: got %02h, required %02h", tx_data, exp_b);
            end
         end
      end
      if (rst_n && err_pulse === 1'b1) err_seen++;
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      syscall_w = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic pulse_raw(input logic [31:0] code, input logic [31:0] arg);
      syscall_w = 1'b1; v0 = code; a0 = arg;
      tick(1);
      syscall_w = 1'b0; v0 = '0; a0 = '0;
   endtask

   task automatic do_syscall(input logic [31:0] code, input logic [31:0] arg);
      int n = 0;
      while (busy && n < 2000) begin tick(1); n++; end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL issue_wait: busy=%0b, required 0 before issue", busy);
      end
      pulse_raw(code, arg);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((busy || tx_valid || exp_q.size() != 0) && n < 3000) begin tick(1); n++; end
      checks++;
      if (busy || tx_valid || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_done: busy=%0b tx_valid=%0b pending=%0d, required 0 0 0",
                  name, busy, tx_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks += 8;
      if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
      if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req: got %0b, required 0", mem_req); end
      if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid: got %0b, required 0", tx_valid); end
      if (halt !== 1'b0)      begin errors++; $display("FAIL rst_halt: got %0b, required 0", halt); end
      if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b, required 0", err_pulse); end
      if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
      if (exit_code !== 32'h0) begin errors++; $display("FAIL rst_exit_code: got %h, required 0", exit_code); end
      if (tx_data !== 8'h00)  begin errors++; $display("FAIL rst_tx_data: got %h, required 0", tx_data); end
   endtask

   task automatic test_print_char();
      logic [7:0] c;
      ready_mode = 1;
      tick(2);
      exp_q.push_back(8'h41);
      do_syscall(32'd11, 32'h41);
      checks += 3;
      if (busy !== 1'b0)     begin errors++; $display("FAIL char_busy: got %0b, required 0", busy); end
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL char_valid: got %0b, required 1", tx_valid); end
      if (tx_data !== 8'h41) begin errors++; $display("FAIL char_data: got %02h, required 41", tx_data); end
      for (int i = 0; i < 6; i++) begin
         c = 8'($urandom_range(0, 255));
         exp_q.push_back(c);
         do_syscall(32'd11, {$urandom_range(0, 255), 24'h0} | {24'h0, c});
      end
      wait_done("char");
   endtask

   task automatic test_fifo_full();
      ready_mode = 0;
      tick(2);
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(8'h61 + 8'(i));
         do_syscall(32'd11, 32'h61 + 32'(i));
         checks++;
         if (busy !== (i == 8)) begin
            errors++;
            $display("FAIL full_busy_%0d: got %0b, required %0b", i, busy, (i == 8));
         end
      end
      tick(3);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b, required 1", busy); end
      ready_mode = 1;
      wait_done("full");
   endtask

   task automatic test_string_hi();
      int e0 = err_seen;
      ack_delay = 2;
      mem_model[10'h100] = 8'h48;
      mem_model[10'h101] = 8'h69;
      mem_model[10'h102] = 8'h00;
      rd_addr_q.delete();
      ready_mode = 1;
      exp_q.push_back(8'h48);
      exp_q.push_back(8'h69);
      do_syscall(32'd4, 32'h100);
      checks += 2;
      if (busy !== 1'b1)    begin errors++; $display("FAIL hi_busy: got %0b, required 1", busy); end
      if (mem_req !== 1'b1) begin errors++; $display("FAIL hi_mem_req: got %0b, required 1", mem_req); end
      wait_done("hi");
      tick(2);
      checks += 2;
      if (rd_addr_q.size() != 3) begin
         errors++;
         $display("FAIL hi_reads: got %0d reads, required 3", rd_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_addr_q[i] !== 32'h100 + 32'(i)) begin
               errors++;
               $display("FAIL hi_addr_%0d: got %h, required %h", i, rd_addr_q[i], 32'h100 + 32'(i));
            end
         end
      end
      if (err_seen != e0) begin errors++; $display("FAIL hi_err: got %0d pulses, required 0", err_seen - e0); end
      ack_delay = -1;
   endtask

   task automatic test_string_random();
      int lens [6] = '{0, 3, 7, 8, 11, 5};
      logic [31:0] addr;
      int n, e0, exp_err;
      ack_delay = -1;
      ready_mode = 2;
      for (int t = 0; t < 6; t++) begin
         addr = (t == 4) ? 32'hFFFF_FFFD : $urandom();
         for (int i = 0; i < lens[t]; i++)
            mem_model[10'(addr + 32'(i))] = 8'($urandom_range(1, 255));
         mem_model[10'(addr + 32'(lens[t]))] = 8'h00;
         n = (lens[t] < TB_MAX_STR) ? lens[t] : TB_MAX_STR;
         for (int i = 0; i < n; i++) exp_q.push_back(mem_model[10'(addr + 32'(i))]);
         exp_err = (lens[t] >= TB_MAX_STR) ? 1 : 0;
         e0 = err_seen;
         do_syscall(32'd4, addr);
         wait_done("str");
         tick(2);
         checks++;
         if (err_seen - e0 != exp_err) begin
            errors++;
            $display("FAIL str_err_len%0d: got %0d pulses, required %0d", lens[t], err_seen - e0, exp_err);
         end
      end
   endtask

   task automatic test_hex();
      logic [31:0] words [5];
      string s;
      int e0;
      words = '{32'hDEADBEEF, 32'h0, 32'hFFFF_FFFF, $urandom(), $urandom()};
      ready_mode = 1;
      tick(2);
      for (int w = 0; w < 5; w++) begin
         s = $sformatf("%08x", words[w]);
         for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
         e0 = err_seen;
         do_syscall(32'd34, words[w]);
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL hex_busy_%0d: got %0b, required 1", w, busy); end
         if (w == 0) pulse_raw(32'd11, 32'h5A);
         wait_done("hex");
         tick(2);
         checks++;
         if (err_seen - e0 != ((w == 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL hex_err_%0d: got %0d pulses, required %0d", w, err_seen - e0, (w == 0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_unknown();
      logic [31:0] codes [3];
      int e0;
      codes = '{32'd99, 32'h1000_000B, 32'd0};
      ready_mode = 1;
      for (int k = 0; k < 3; k++) begin
         e0 = err_seen;
         do_syscall(codes[k], $urandom());
         tick(3);
         checks += 2;
         if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL unk_err_%0d: got %0d pulses, required 1", k, err_seen - e0);
         end
         if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL unk_idle_%0d: got valid=%0b busy=%0b, required 0 0", k, tx_valid, busy);
         end
      end
   endtask

   task automatic test_reset_mid_string();
      ready_mode = 0;
      ack_delay = 3;
      tick(2);
      for (int i = 0; i < 20; i++) mem_model[10'h200 + 10'(i)] = 8'h41 + 8'(i);
      mem_model[10'h214] = 8'h00;
      do_syscall(32'd4, 32'h200);
      tick(10);
      checks += 2;
      if (mem_req !== 1'b1)  begin errors++; $display("FAIL mid_req: got %0b, required 1", mem_req); end
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %0b, required 1", tx_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req, tx_valid, halt, err_pulse, mem_addr, exit_code, tx_data} !== '0) begin
         errors++;
         $display("FAIL mid_reset: busy=%0b req=%0b valid=%0b halt=%0b err=%0b addr=%h code=%h data=%h, required all 0",
                  busy, mem_req, tx_valid, halt, err_pulse, mem_addr, exit_code, tx_data);
      end
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      ack_delay = -1;
      tick(6);
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: busy=%0b valid=%0b req=%0b, required 0 0 0", busy, tx_valid, mem_req);
      end
   endtask

   task automatic test_exit(input logic [31:0] code, input logic [31:0] arg, input logic [31:0] exp_code);
      int n = 0;
      int e0;
      ready_mode = 0;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'h30 + 8'(i));
         do_syscall(32'd11, 32'h30 + 32'(i));
      end
      do_syscall(code, arg);
      tick(5);
      checks += 2;
      if (halt !== 1'b0) begin errors++; $display("FAIL exit_early_halt: got %0b, required 0", halt); end
      if (busy !== 1'b1) begin errors++; $display("FAIL exit_drain_busy: got %0b, required 1", busy); end
      ready_mode = 1;
      while (halt !== 1'b1 && n < 200) begin tick(1); n++; end
      checks += 4;
      if (halt !== 1'b1) begin errors++; $display("FAIL exit_halt: got %0b, required 1", halt); end
      if (exp_q.size() != 0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL exit_drained: pending=%0d valid=%0b, required 0 0", exp_q.size(), tx_valid);
      end
      if (exit_code !== exp_code) begin errors++; $display("FAIL exit_code: got %h, required %h", exit_code, exp_code); end
      if (busy !== 1'b1) begin errors++; $display("FAIL exit_busy: got %0b, required 1", busy); end
      e0 = err_seen;
      pulse_raw(32'd11, 32'h51);
      tick(4);
      checks += 2;
      if (err_seen - e0 != 1) begin errors++; $display("FAIL halt_err: got %0d pulses, required 1", err_seen - e0); end
      if (halt !== 1'b1 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_sticky: halt=%0b valid=%0b, required 1 0", halt, tx_valid);
      end
      apply_reset();
      checks++;
      if (halt !== 1'b0 || exit_code !== 32'h0) begin
         errors++;
         $display("FAIL exit_reset: halt=%0b code=%h, required 0 0", halt, exit_code);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
      tick(1);
      test_reset();
      test_print_char();
      test_fifo_full();
      test_string_hi();
      test_string_random();
      test_hex();
      test_unknown();
      test_reset_mid_string();
      test_exit(32'd17, 32'd7, 32'd7);
      test_exit(32'd10, $urandom() | 32'h1, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
